// File: rtl/univ_shift_reg_n.sv
// Universal WIDTH-bit shift register: hold, load, variable logical/arithmetic shifts,
// rotates, and a self-timed LSB-first burst serializer with busy/done status.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             lin,
    input  logic             rin,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_SHR   = 3'd1,
        OP_SHL   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ASR   = 3'd6,
        OP_BURST = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int             IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AMT_W:0] WIDTH_X = (AMT_W+1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONES  = '1;

    state_e           state, state_n;
    op_e              op;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dout_n;
    logic             sout_n;
    logic             done_n;

    logic             amt_zero;
    logic             amt_big;
    logic [AMT_W:0]   rot;
    logic [IDX_W-1:0] idx_shr;
    logic [IDX_W-1:0] idx_shl;
    logic [WIDTH-1:0] shr_res;
    logic [WIDTH-1:0] asr_res;
    logic [WIDTH-1:0] shl_res;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] rol_res;

    // Shift results use fill masks so amt >= WIDTH naturally yields all-fill.
    always_comb begin
        op       = op_e'(mode);
        amt_zero = (amt == '0);
        amt_big  = ({1'b0, amt} >= WIDTH_X);
        rot      = {1'b0, amt} % WIDTH_X;
        idx_shr  = IDX_W'(amt - AMT_W'(1));
        idx_shl  = IDX_W'(WIDTH_X - {1'b0, amt});
        shr_res  = (dout >> amt) | (lin ? ~(ONES >> amt) : '0);
        asr_res  = (dout >> amt) | (dout[WIDTH-1] ? ~(ONES >> amt) : '0);
        shl_res  = (dout << amt) | (rin ? ~(ONES << amt) : '0);
        ror_res  = (dout >> rot) | (dout << (WIDTH_X - rot));
        rol_res  = (dout << rot) | (dout >> (WIDTH_X - rot));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        sout_n  = sout;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                case (op)
                    OP_HOLD: ;
                    OP_SHR: begin
                        if (!amt_zero) begin
                            dout_n = shr_res;
                            sout_n = amt_big ? lin : dout[idx_shr];
                        end
                    end
                    OP_SHL: begin
                        if (!amt_zero) begin
                            dout_n = shl_res;
                            sout_n = amt_big ? rin : dout[idx_shl];
                        end
                    end
                    OP_LOAD: dout_n = din;
                    OP_ROR: begin
                        if (!amt_zero) begin
                            dout_n = ror_res;
                            sout_n = ror_res[WIDTH-1];
                        end
                    end
                    OP_ROL: begin
                        if (!amt_zero) begin
                            dout_n = rol_res;
                            sout_n = rol_res[0];
                        end
                    end
                    OP_ASR: begin
                        if (!amt_zero) begin
                            dout_n = asr_res;
                            sout_n = amt_big ? dout[WIDTH-1] : dout[idx_shr];
                        end
                    end
                    OP_BURST: begin
                        dout_n = din;
                        cnt_n  = amt;
                        if (amt_zero) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = ST_BURST;
                        end
                    end
                    default: ;
                endcase
            end
            ST_BURST: begin
                dout_n = {lin, dout[WIDTH-1:1]};
                sout_n = dout[0];
                cnt_n  = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dout  <= '0;
            sout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
            sout  <= sout_n;
            done  <= done_n;
        end
    end

    assign busy = (state == ST_BURST);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n: a bit-level reference model checked every cycle,
// plus literal expectations from hand-computed vectors.
module tb_univ_shift_reg_n;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  din = '0;
    logic [2:0]    mode = '0;
    logic [AW-1:0] amt = '0;
    logic          lin = 1'b0;
    logic          rin = 1'b0;
    logic [W-1:0]  dout;
    logic          sout;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_dout;
    logic         m_sout;
    logic         m_busy;
    logic         m_done;
    int           m_cnt;
    bit           m_valid = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .mode (mode),
        .amt  (amt),
        .lin  (lin),
        .rin  (rin),
        .dout (dout),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each output bit is derived from its source position.
    initial begin
        logic         rs, l, ri, fill;
        logic [W-1:0] d, nd;
        logic         ns, nbusy, ndone;
        int           md, a, r2;
        forever begin
            @(posedge clk);
            rs = reset; md = int'(mode); a = int'(amt); d = din; l = lin; ri = rin;
            nd = m_dout; ns = m_sout; nbusy = m_busy; ndone = 1'b0;
            if (rs) begin
                nd = '0; ns = 1'b0; nbusy = 1'b0; m_cnt = 0; m_valid = 1'b1;
            end else if (m_busy) begin
                ns = m_dout[0];
                for (int i = 0; i < W; i++) nd[i] = (i + 1 < W) ? m_dout[i+1] : l;
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    nbusy = 1'b0;
                    ndone = 1'b1;
                end
            end else begin
                case (md)
                    1, 6: if (a != 0) begin
                        fill = (md == 1) ? l : m_dout[W-1];
                        for (int i = 0; i < W; i++) nd[i] = (i + a < W) ? m_dout[i+a] : fill;
                        ns = (a >= W) ? fill : m_dout[a-1];
                    end
                    2: if (a != 0) begin
                        for (int i = 0; i < W; i++) nd[i] = (i >= a) ? m_dout[i-a] : ri;
                        ns = (a >= W) ? ri : m_dout[W-a];
                    end
                    3: nd = d;
                    4: if (a != 0) begin
                        r2 = a % W;
                        for (int i = 0; i < W; i++) nd[i] = m_dout[(i + r2) % W];
                        ns = nd[W-1];
                    end
                    5: if (a != 0) begin
                        r2 = a % W;
                        for (int i = 0; i < W; i++) nd[i] = m_dout[(i + W - r2) % W];
                        ns = nd[0];
                    end
                    7: begin
                        nd = d;
                        m_cnt = a;
                        if (a == 0) ndone = 1'b1;
                        else nbusy = 1'b1;
                    end
                    default: ;
                endcase
            end
            m_dout = nd; m_sout = ns; m_busy = nbusy; m_done = ndone;
            #1;
            if (m_valid) begin
                chk("cyc_dout", dout, m_dout);
                chk("cyc_sout", sout, m_sout);
                chk("cyc_busy", busy, m_busy);
                chk("cyc_done", done, m_done);
            end
        end
    end

    task automatic step(input logic rs, input logic [2:0] md, input logic [W-1:0] d,
                        input logic [AW-1:0] a, input logic l, input logic ri);
        @(negedge clk);
        reset = rs; mode = md; din = d; amt = a; lin = l; rin = ri;
        @(posedge clk);
        #2;
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic [W-1:0] ed);
        chk(name, dout, ed);
        chk({name, "_model"}, m_dout, ed);
    endtask

    task automatic lits(input string name, input logic es);
        chk(name, sout, es);
        chk({name, "_model"}, m_sout, es);
    endtask

    initial begin
        logic seq [8];
        seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        step(1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0);
        lit("rst_dout", 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        lits("rst_sout", 1'b0);

        step(0, 3, 8'hA5, 0, 0, 0); lit("load_a5", 8'hA5);
        step(0, 1, 8'h00, 3, 1, 0); lit("shr3", 8'hF4); lits("shr3_sout", 1'b1);
        step(0, 3, 8'hA5, 0, 0, 0);
        step(0, 2, 8'h00, 2, 0, 0); lit("shl2", 8'h94); lits("shl2_sout", 1'b0);
        step(0, 3, 8'h96, 0, 0, 0);
        step(0, 6, 8'h00, 4, 0, 0); lit("asr4", 8'hF9); lits("asr4_sout", 1'b0);
        step(0, 3, 8'hA5, 0, 0, 0);
        step(0, 1, 8'h00, 9, 0, 0); lit("shr9", 8'h00); lits("shr9_sout", 1'b0);
        step(0, 3, 8'hA5, 0, 0, 0);
        step(0, 1, 8'h00, 8, 1, 0); lit("shr8_fill", 8'hFF); lits("shr8_sout", 1'b1);
        step(0, 3, 8'h5A, 0, 0, 0);
        step(0, 2, 8'h00, 12, 0, 1); lit("shl12_fill", 8'hFF); lits("shl12_sout", 1'b1);
        step(0, 3, 8'h80, 0, 0, 0);
        step(0, 6, 8'h00, 15, 0, 0); lit("asr15", 8'hFF); lits("asr15_sout", 1'b1);

        step(0, 3, 8'h01, 0, 0, 0);
        step(0, 4, 8'h00, 1, 0, 0); lit("ror1", 8'h80); lits("ror1_sout", 1'b1);
        step(0, 3, 8'h3C, 0, 0, 0);
        step(0, 5, 8'h00, 8, 0, 0); lit("rol8", 8'h3C); lits("rol8_sout", 1'b0);
        step(0, 5, 8'h00, 3, 0, 0); lit("rol3", 8'hE1); lits("rol3_sout", 1'b1);
        step(0, 4, 8'h00, 9, 0, 0); lit("ror9", 8'hF0); lits("ror9_sout", 1'b1);
        step(0, 2, 8'h00, 1, 0, 0); lit("shl1", 8'hE0); lits("shl1_sout", 1'b1);
        step(0, 1, 8'h00, 1, 0, 0); lit("shr1", 8'h70); lits("shr1_sout", 1'b0);

        foreach (seq[k]) begin
            step(0, 3'(k % 5 + 1 + ((k % 5) >= 2 ? 1 : 0)), 8'h00, 0, 1, 1);
            lit("amt0_dout", 8'h70);
            lits("amt0_sout", 1'b0);
        end

        step(0, 7, 8'hB2, 8, 0, 0);
        lit("burst_load", 8'hB2);
        chk("burst_busy0", busy, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 3, 8'h55, 3, 0, 0);
            lits("burst_sout", seq[k]);
            chk("burst_busy", busy, (k < 7) ? 1 : 0);
            chk("burst_done", done, (k == 7) ? 1 : 0);
        end
        lit("burst_end", 8'h00);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("burst_done_clr", done, 0);

        step(0, 7, 8'h5A, 0, 0, 0);
        lit("burst0_load", 8'h5A); chk("burst0_busy", busy, 0); chk("burst0_done", done, 1);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("burst0_busy2", busy, 0); chk("burst0_done2", done, 0);

        step(0, 7, 8'hC3, 2, 0, 0); lit("b2b_load1", 8'hC3);
        step(0, 7, 8'h0F, 2, 0, 0); lit("b2b_s1", 8'h61); chk("b2b_busy1", busy, 1);
        step(0, 7, 8'h0F, 2, 0, 0); lit("b2b_s2", 8'h30); chk("b2b_done1", done, 1);
        step(0, 7, 8'h0F, 2, 0, 0); lit("b2b_load2", 8'h0F); chk("b2b_busy2", busy, 1);
        step(0, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0); lit("b2b_end", 8'h03); chk("b2b_done2", done, 1);

        step(0, 7, 8'hFF, 8, 1, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        step(1, 7, 8'hAA, 3, 1, 0);
        lit("midrst_dout", 8'h00); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 8'h00, 0, 1, 0);
        chk("midrst_nodone", done, 0);
        step(0, 3, 8'h77, 0, 0, 0); lit("post_rst_load", 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
